// File: rtl/scan_step_sequencer.sv
// scan_step_sequencer: steps a DAC threshold, fires one counter gate per point
// and hands each captured count/time downstream under valid/ready.
module scan_step_sequencer #(
  parameter int DAC_WIDTH     = 12,
  parameter int STEP_WIDTH    = 16,
  parameter int SETTLE_CYCLES = 5000,
  parameter int CLK_HZ        = 50000000,
  parameter int TMO_MARGIN_S  = 2
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic                  scan_go,
  input  logic                  abort,
  input  logic [DAC_WIDTH-1:0]  cfg_dac0,
  input  logic [DAC_WIDTH-1:0]  cfg_step,
  input  logic [STEP_WIDTH-1:0] cfg_npts,
  input  logic [7:0]            cfg_gate_s,
  output logic [DAC_WIDTH-1:0]  dac_value,
  output logic                  dac_load,
  input  logic                  dac_busy,
  input  logic                  cnt_ready,
  output logic                  cnt_start,
  input  logic                  cnt_stop,
  input  logic [31:0]           cnt_data,
  input  logic [31:0]           cnt_time,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [STEP_WIDTH-1:0] res_idx,
  output logic [DAC_WIDTH-1:0]  res_dac,
  output logic [31:0]           res_count,
  output logic [31:0]           res_time,
  output logic                  busy,
  output logic                  done,
  output logic                  scan_sat,
  output logic                  scan_err
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int PW = $clog2(CLK_HZ + 1);
  typedef enum logic [3:0] {
    IDLE, SET_DAC, WAIT_DAC, SETTLE, WAIT_RDY, START, WAIT_STOP, PUSH, NEXT, DONE
  } state_t;
  state_t                state;
  logic [DAC_WIDTH-1:0]  step_r, cur;
  logic [STEP_WIDTH-1:0] npts_r, idx;
  logic [7:0]            gate_r;
  logic                  first;
  logic [SW-1:0]         scnt;
  logic [PW-1:0]         pre;
  logic [9:0]            sec;
  logic [DAC_WIDTH:0]    nxt;
  logic [9:0]            limit;
  // one extra bit so an overflowing threshold is detected instead of wrapping
  assign nxt   = {1'b0, cur} + {1'b0, step_r};
  assign limit = {2'b00, gate_r} + 10'(TMO_MARGIN_S);
  assign busy  = state != IDLE;
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state     <= IDLE;
      step_r    <= '0;
      cur       <= '0;
      npts_r    <= '0;
      idx       <= '0;
      gate_r    <= '0;
      first     <= 1'b0;
      scnt      <= '0;
      pre       <= '0;
      sec       <= '0;
      dac_value <= '0;
      dac_load  <= 1'b0;
      cnt_start <= 1'b0;
      res_valid <= 1'b0;
      res_idx   <= '0;
      res_dac   <= '0;
      res_count <= '0;
      res_time  <= '0;
      done      <= 1'b0;
      scan_sat  <= 1'b0;
      scan_err  <= 1'b0;
    end else begin
      dac_load  <= 1'b0;
      cnt_start <= 1'b0;
      done      <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        res_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: if (scan_go) begin
            step_r   <= cfg_step;
            npts_r   <= cfg_npts;
            gate_r   <= cfg_gate_s;
            idx      <= '0;
            cur      <= cfg_dac0;
            scan_sat <= 1'b0;
            scan_err <= 1'b0;
            state    <= cfg_npts == '0 ? DONE : SET_DAC;
          end
          SET_DAC: begin
            dac_value <= cur;
            dac_load  <= 1'b1;
            first     <= 1'b1;
            state     <= WAIT_DAC;
          end
          WAIT_DAC: begin
            first <= 1'b0;
            scnt  <= '0;
            if (!first && !dac_busy) state <= SETTLE;
          end
          SETTLE: begin
            scnt <= scnt + 1'b1;
            if (scnt == SW'(SETTLE_CYCLES - 1)) state <= WAIT_RDY;
          end
          WAIT_RDY: if (cnt_ready) state <= START;
          START: begin
            cnt_start <= 1'b1;
            pre       <= '0;
            sec       <= '0;
            state     <= WAIT_STOP;
          end
          WAIT_STOP: begin
            if (cnt_stop) begin
              res_count <= cnt_data;
              res_time  <= cnt_time;
              res_idx   <= idx;
              res_dac   <= cur;
              res_valid <= 1'b1;
              state     <= PUSH;
            end else if (pre == PW'(CLK_HZ - 1)) begin
              pre <= '0;
              sec <= sec + 10'd1;
              if (sec + 10'd1 == limit) begin
                scan_err <= 1'b1;
                state    <= IDLE;
              end
            end else begin
              pre <= pre + 1'b1;
            end
          end
          PUSH: if (res_ready) begin
            res_valid <= 1'b0;
            state     <= NEXT;
          end
          NEXT: begin
            if (idx == npts_r - 1'b1) begin
              state <= DONE;
            end else if (nxt[DAC_WIDTH]) begin
              scan_sat <= 1'b1;
              state    <= DONE;
            end else begin
              cur   <= nxt[DAC_WIDTH-1:0];
              idx   <= idx + 1'b1;
              state <= SET_DAC;
            end
          end
          DONE: begin
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_scan_step_sequencer.sv
// tb_scan_step_sequencer: directed bench with a small DAC/counter responder;
// short settle and a 20-cycle "second" keep the watchdog run brief.
module tb_scan_step_sequencer;
  localparam int DW = 12;
  localparam int SWD = 16;
  logic clk = 1'b0;
  logic res_n = 1'b0;
  logic scan_go = 1'b0, abort = 1'b0;
  logic [DW-1:0] cfg_dac0 = '0, cfg_step = '0;
  logic [SWD-1:0] cfg_npts = '0;
  logic [7:0] cfg_gate_s = 8'd1;
  logic [DW-1:0] dac_value, res_dac;
  logic dac_load, cnt_start, res_valid, busy, done, scan_sat, scan_err;
  logic dac_busy = 1'b0, cnt_ready = 1'b1, cnt_stop = 1'b0, res_ready = 1'b1;
  logic [31:0] cnt_data = '0, cnt_time = '0, res_count, res_time;
  logic [SWD-1:0] res_idx;
  int checks = 0, failures = 0;
  int done_cnt = 0, load_cnt = 0, xfer_cnt = 0, start_cnt = 0;
  int bcnt = 0, gcnt = 0;
  bit stop_en = 1'b1;

  scan_step_sequencer #(
    .DAC_WIDTH(DW), .STEP_WIDTH(SWD), .SETTLE_CYCLES(3), .CLK_HZ(20), .TMO_MARGIN_S(2)
  ) dut (
    .clk(clk), .res_n(res_n), .scan_go(scan_go), .abort(abort),
    .cfg_dac0(cfg_dac0), .cfg_step(cfg_step), .cfg_npts(cfg_npts), .cfg_gate_s(cfg_gate_s),
    .dac_value(dac_value), .dac_load(dac_load), .dac_busy(dac_busy),
    .cnt_ready(cnt_ready), .cnt_start(cnt_start), .cnt_stop(cnt_stop),
    .cnt_data(cnt_data), .cnt_time(cnt_time),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx), .res_dac(res_dac),
    .res_count(res_count), .res_time(res_time),
    .busy(busy), .done(done), .scan_sat(scan_sat), .scan_err(scan_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (dac_load) load_cnt <= load_cnt + 1;
    if (cnt_start) start_cnt <= start_cnt + 1;
    if (res_valid && res_ready) xfer_cnt <= xfer_cnt + 1;
  end

  // DAC stays busy two cycles after a load; counter ends its gate five cycles
  // after start, reporting count=1000+dac and time=2000+dac.
  always @(negedge clk) begin
    if (dac_load) begin
      dac_busy = 1'b1;
      bcnt = 2;
    end else if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) dac_busy = 1'b0;
    end
    if (cnt_start) begin
      cnt_stop = 1'b0;
      gcnt = 5;
    end else if (gcnt > 0) begin
      gcnt--;
      if (gcnt == 0 && stop_en) begin
        cnt_stop = 1'b1;
        cnt_data = 32'(dac_value) + 32'd1000;
        cnt_time = 32'(dac_value) + 32'd2000;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic go();
    @(negedge clk);
    scan_go = 1'b1;
    @(negedge clk);
    scan_go = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = res_valid;
    end
    chk(tag, 32'(seen), 1);
  endtask

  task automatic expect_result(input string tag, input int i, input int d);
    wait_valid({tag, "_valid"});
    chk({tag, "_idx"}, 32'(res_idx), i);
    chk({tag, "_dac"}, 32'(res_dac), d);
    chk({tag, "_count"}, res_count, 1000 + d);
    chk({tag, "_time"}, res_time, 2000 + d);
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    chk(tag, 32'(seen), 1);
    @(negedge clk);
  endtask

  initial begin
    int d0, x0, l0, s0, k, err_mid;
    bit seen, bad;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_load", 32'(dac_load), 0);
    chk("rst_start", 32'(cnt_start), 0);
    chk("rst_flags", {30'd0, scan_sat, scan_err}, 0);
    chk("rst_dac", 32'(dac_value), 0);
    res_n = 1'b1;
    // three-point scan; config is scribbled after start and must be ignored
    cfg_dac0 = 12'd100; cfg_step = 12'd10; cfg_npts = 16'd3; cfg_gate_s = 8'd1;
    d0 = done_cnt; x0 = xfer_cnt;
    go();
    chk("scan_busy", 32'(busy), 1);
    cfg_dac0 = 12'd999; cfg_step = 12'd1; cfg_npts = 16'd9;
    expect_result("p0", 0, 100);
    expect_result("p1", 1, 110);
    expect_result("p2", 2, 120);
    wait_done("scan_done");
    chk("scan_done_cnt", done_cnt - d0, 1);
    chk("scan_xfers", xfer_cnt - x0, 3);
    chk("scan_sat0", 32'(scan_sat), 0);
    chk("scan_idle", 32'(busy), 0);
    // empty scan: done two edges after scan_go, nothing else happens
    cfg_npts = 16'd0;
    l0 = load_cnt; x0 = xfer_cnt;
    go();
    chk("empty_done_e1", 32'(done), 0);
    @(negedge clk);
    chk("empty_done_e2", 32'(done), 1);
    @(negedge clk);
    chk("empty_done_e3", 32'(done), 0);
    chk("empty_no_load", load_cnt - l0, 0);
    chk("empty_no_xfer", xfer_cnt - x0, 0);
    // DAC range exhausted after 4094
    cfg_dac0 = 12'd4090; cfg_step = 12'd4; cfg_npts = 16'd5;
    x0 = xfer_cnt; d0 = done_cnt;
    go();
    expect_result("sat0", 0, 4090);
    expect_result("sat1", 1, 4094);
    wait_done("sat_done");
    chk("sat_flag", 32'(scan_sat), 1);
    chk("sat_xfers", xfer_cnt - x0, 2);
    chk("sat_done_cnt", done_cnt - d0, 1);
    // downstream stall for 100 cycles
    cfg_dac0 = 12'd50; cfg_step = 12'd1; cfg_npts = 16'd1;
    res_ready = 1'b0; x0 = xfer_cnt;
    go();
    chk("bp_sat_cleared", 32'(scan_sat), 0);
    expect_result("bp", 0, 50);
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_dac !== 12'd50 || res_idx !== 16'd0 ||
          res_count !== 32'd1050 || res_time !== 32'd2050) bad = 1'b1;
    end
    chk("bp_frozen", 32'(bad), 0);
    chk("bp_no_xfer", xfer_cnt - x0, 0);
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_drop", 32'(res_valid), 0);
    wait_done("bp_done");
    chk("bp_one_xfer", xfer_cnt - x0, 1);
    // watchdog: gate never ends, 1 s gate + 2 s margin = 60 cycles
    stop_en = 1'b0;
    cfg_dac0 = 12'd10; cfg_npts = 16'd2; cfg_gate_s = 8'd1;
    d0 = done_cnt;
    go();
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = cnt_start;
    end
    chk("tmo_start", 32'(seen), 1);
    k = 0; err_mid = 0;
    for (int i = 0; i < 200 && busy; i++) begin
      @(negedge clk);
      k++;
      if (k == 30) err_mid = 32'(scan_err);
    end
    chk("tmo_err_mid", err_mid, 0);
    chk("tmo_cycles", k, 60);
    chk("tmo_err", 32'(scan_err), 1);
    @(negedge clk);
    chk("tmo_no_done", done_cnt - d0, 0);
    stop_en = 1'b1;
    // abort while settling
    cfg_dac0 = 12'd20; cfg_npts = 16'd2;
    d0 = done_cnt; s0 = start_cnt;
    go();
    chk("go_clears_err", 32'(scan_err), 0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = dac_load;
    end
    chk("ab_load_seen", 32'(seen), 1);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_settle_idle", 32'(busy), 0);
    chk("ab_settle_valid", 32'(res_valid), 0);
    repeat (20) @(negedge clk);
    chk("ab_settle_no_start", start_cnt - s0, 0);
    chk("ab_settle_no_done", done_cnt - d0, 0);
    // abort while a result waits for downstream
    cfg_dac0 = 12'd30; res_ready = 1'b0;
    x0 = xfer_cnt;
    go();
    wait_valid("ab_push_valid");
    chk("ab_push_dac", 32'(res_dac), 30);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_push_valid_drop", 32'(res_valid), 0);
    chk("ab_push_idle", 32'(busy), 0);
    res_ready = 1'b1;
    repeat (30) @(negedge clk);
    chk("ab_push_no_xfer", xfer_cnt - x0, 0);
    chk("ab_push_no_done", done_cnt - d0, 0);
    // abort wins over scan_go in the same cycle
    scan_go = 1'b1; abort = 1'b1;
    @(negedge clk);
    scan_go = 1'b0; abort = 1'b0;
    chk("abort_beats_go", 32'(busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
